// File: rtl/icache_l0_pkg.sv
// icache_l0_pkg: shared constants and fill-FSM state encoding for the L0 instruction cache
package icache_l0_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_COMMIT} fill_state_e;
endpackage

// File: rtl/icache_fill_fsm.sv
// icache_fill_fsm: line-fill sequencer, one bus request outstanding, word by word
module icache_fill_fsm
  import icache_l0_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  parameter int ADDR_WIDTH = 32,
  localparam int OFFB = $clog2(WORDS),
  localparam int IDXB = $clog2(LINES),
  localparam int LW = ADDR_WIDTH - OFFB - 2,
  localparam int TW = LW - IDXB
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic                  lookup_miss,
  input  logic [LW-1:0]         line_addr_in,
  input  logic                  inval_in,
  input  logic                  mem_gnt_in,
  input  logic                  mem_rvalid_in,
  output logic                  idle_out,
  output logic                  mem_req_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic                  fill_we_out,
  output logic                  commit_out,
  output logic                  clr_all_out,
  output logic [OFFB-1:0]       fill_off_out,
  output logic [IDXB-1:0]       fill_idx_out,
  output logic [TW-1:0]         fill_tag_out
);
  fill_state_e state_q, state_d;
  logic [OFFB-1:0] k_q, k_d;
  logic pend_q, pend_d;
  logic [LW-1:0] base_q, base_d;
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      pend_q  <= 1'b0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      pend_q  <= pend_d;
      base_q  <= base_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    pend_d      = pend_q;
    base_d      = base_q;
    mem_req_out = 1'b0;
    fill_we_out = 1'b0;
    commit_out  = 1'b0;
    clr_all_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        clr_all_out = inval_in;
        if (lookup_miss) begin
          base_d  = line_addr_in;
          k_d     = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_out = 1'b1;
        pend_d      = pend_q | inval_in;
        state_d     = mem_gnt_in ? S_WAIT : S_REQ;
      end
      S_WAIT: begin
        pend_d      = pend_q | inval_in;
        fill_we_out = mem_rvalid_in;
        if (mem_rvalid_in) begin
          state_d = (k_q == OFFB'(WORDS - 1)) ? S_COMMIT : S_REQ;
          k_d     = k_q + 1'b1;
        end
      end
      default: begin
        // an invalidate seen anywhere in the fill also drops the line just filled
        clr_all_out = pend_q | inval_in;
        commit_out  = !(pend_q | inval_in);
        pend_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end
  assign idle_out     = (state_q == S_IDLE);
  assign mem_addr_out = mem_req_out ? {base_q, k_q, 2'b00} : '0;
  assign fill_off_out = k_q;
  assign fill_idx_out = base_q[IDXB-1:0];
  assign fill_tag_out = base_q[LW-1:IDXB];
endmodule

// File: rtl/icache_l0.sv
// icache_l0: direct-mapped read-only L0 instruction cache with combinational hit path
module icache_l0
  import icache_l0_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_in,
  output logic [31:0]           fetch_data_out,
  output logic                  fetch_valid_out,
  output logic                  stall_out,
  input  logic                  inval_in,
  output logic                  mem_req_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic                  mem_gnt_in,
  input  logic                  mem_rvalid_in,
  input  logic [31:0]           mem_rdata_in
);
  localparam int OFFB = $clog2(WORDS);
  localparam int IDXB = $clog2(LINES);
  localparam int TW = ADDR_WIDTH - OFFB - IDXB - 2;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0] tag_q [LINES];
  logic [TW-1:0] tag_d [LINES];
  logic [31:0] data_q [LINES*WORDS];
  logic [31:0] data_d [LINES*WORDS];
  logic [OFFB-1:0] off, fill_off;
  logic [IDXB-1:0] idx, fill_idx;
  logic [TW-1:0] tag, fill_tag;
  logic idle, hit, miss, fill_we, commit, clr_all;
  logic [1:0] unused_byte;
  assign unused_byte = fetch_addr_in[1:0];
  assign off = fetch_addr_in[OFFB+1:2];
  assign idx = fetch_addr_in[OFFB+IDXB+1:OFFB+2];
  assign tag = fetch_addr_in[ADDR_WIDTH-1:OFFB+IDXB+2];
  assign hit = idle && valid_q[idx] && (tag_q[idx] == tag);
  assign miss = idle && !hit;
  assign fetch_valid_out = hit;
  assign stall_out = !hit;
  assign fetch_data_out = hit ? data_q[{idx, off}] : NOP;
  icache_fill_fsm #(.LINES(LINES), .WORDS(WORDS), .ADDR_WIDTH(ADDR_WIDTH)) u_fsm (
    .clock_in     (clock_in),
    .reset_n_in   (reset_n_in),
    .lookup_miss  (miss),
    .line_addr_in (fetch_addr_in[ADDR_WIDTH-1:OFFB+2]),
    .inval_in     (inval_in),
    .mem_gnt_in   (mem_gnt_in),
    .mem_rvalid_in(mem_rvalid_in),
    .idle_out     (idle),
    .mem_req_out  (mem_req_out),
    .mem_addr_out (mem_addr_out),
    .fill_we_out  (fill_we),
    .commit_out   (commit),
    .clr_all_out  (clr_all),
    .fill_off_out (fill_off),
    .fill_idx_out (fill_idx),
    .fill_tag_out (fill_tag)
  );
  always_comb begin
    valid_d = clr_all ? '0 : valid_q;
    // the missing line is dropped as the fill starts so a partial line never hits
    if (miss) valid_d[idx] = 1'b0;
    if (commit) valid_d[fill_idx] = 1'b1;
    tag_d = tag_q;
    if (commit) tag_d[fill_idx] = fill_tag;
    data_d = data_q;
    if (fill_we) data_d[{fill_idx, fill_off}] = mem_rdata_in;
  end
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) valid_q <= '0;
    else valid_q <= valid_d;
  end
  always_ff @(posedge clock_in) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule
